mem_arbiter: RTL

//  Arbitrates one shared single-port RAM between instruction fetch (PC/icache side)
//  and data access (dcache side).

---
 rtl/mem_arbiter_if.sv | 38 +++
 rtl/mem_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
//==============================================================================
// Module      : mem_arbiter_if
// Description : Fetch, data and RAM-side signals of the shared-RAM arbiter.
// Revision    : 1.0
//==============================================================================
`default_nettype none

interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        ihit;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dhit;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ram_rdy;
    logic        mem_err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_rdy,
        output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_rdy,
        input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
    );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
//==============================================================================
// Module      : mem_arbiter
// Description : Shares one single-port RAM between fetch and data, data first,
//               with a per-access timeout that aborts hung RAM accesses.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] ERR_WORD = 32'hBAD1BAD1
) (
    input  wire logic     clk,
    input  wire logic     rst,
    mem_arbiter_if.slave  bus
);
    localparam int unsigned          CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_IACC = 2'd1,
        S_DACC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      addr_q;
    logic [31:0]      store_q;
    logic             op_wr_q;
    logic             ren_q;
    logic             wen_q;
    logic             ihit_q;
    logic             dhit_q;
    logic [31:0]      iload_q;
    logic [31:0]      dload_q;
    logic             err_q;
    logic [31:0]      w_load;

    // A ready on the final counted cycle still counts as a normal completion.
    assign w_load = bus.ram_rdy ? bus.ramload : ERR_WORD;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            store_q <= '0;
            op_wr_q <= 1'b0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            ihit_q  <= 1'b0;
            dhit_q  <= 1'b0;
            iload_q <= '0;
            dload_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (bus.dREN || bus.dWEN) begin
                        state_q <= S_DACC;
                        addr_q  <= bus.daddr;
                        store_q <= bus.dWEN ? bus.dstore : 32'd0;
                        op_wr_q <= bus.dWEN;
                        ren_q   <= ~bus.dWEN;
                        wen_q   <= bus.dWEN;
                    end else if (bus.iREN) begin
                        state_q <= S_IACC;
                        addr_q  <= bus.iaddr;
                        store_q <= 32'd0;
                        op_wr_q <= 1'b0;
                        ren_q   <= 1'b1;
                        wen_q   <= 1'b0;
                    end
                end
                S_IACC, S_DACC: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (bus.ram_rdy || (cnt_q == CNT_LAST)) begin
                        state_q <= S_DONE;
                        ren_q   <= 1'b0;
                        wen_q   <= 1'b0;
                        if (state_q == S_IACC) begin
                            ihit_q  <= 1'b1;
                            iload_q <= w_load;
                        end else begin
                            dhit_q <= 1'b1;
                            if (!op_wr_q) begin
                                dload_q <= w_load;
                            end
                        end
                        if (!bus.ram_rdy) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    ihit_q  <= 1'b0;
                    dhit_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.ihit     = ihit_q;
    assign bus.iload    = iload_q;
    assign bus.dhit     = dhit_q;
    assign bus.dload    = dload_q;
    assign bus.ramREN   = ren_q;
    assign bus.ramWEN   = wen_q;
    assign bus.ramaddr  = addr_q;
    assign bus.ramstore = store_q;
    assign bus.mem_err  = err_q;

endmodule

`default_nettype wire
